// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: encodings, sentinel values,
// FSM states and the IF/ID bundle layout.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] IF_NOP    = 32'h0000_0000;
  localparam logic [XLEN-1:0] IF_BRK_PC = 32'hFFFF_FFFF;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } if_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle between the fetch stage and its neighbours: PC register, hazard unit,
// instruction memory and the IF/ID consumer.
interface if_stage_if #(
  parameter int unsigned AW = 8
);
  import if_stage_pkg::*;

  logic [XLEN-1:0] PC;
  logic            Stall;
  logic            Flush;
  logic            Continue;
  logic [XLEN-1:0] IMemRdata;

  logic [XLEN-1:0] PCPlus4;
  logic            IMemEn;
  logic [AW-1:0]   IMemAddr;
  logic [XLEN-1:0] IF_ID_Instr;
  logic [XLEN-1:0] IF_ID_PC;
  logic [XLEN-1:0] IF_ID_PCPlus4;
  logic            IF_ID_Valid;
  logic            Halted;
  logic [XLEN-1:0] FetchCount;

  modport master (
    output PC, Stall, Flush, Continue, IMemRdata,
    input  PCPlus4, IMemEn, IMemAddr, IF_ID_Instr, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Valid,
    input  Halted, FetchCount
  );

  modport slave (
    input  PC, Stall, Flush, Continue, IMemRdata,
    output PCPlus4, IMemEn, IMemAddr, IF_ID_Instr, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Valid,
    output Halted, FetchCount
  );

endinterface

// File: rtl/if_skid_buf.sv
// Captures the memory response when a stall begins, since the memory output may change
// while its enable is low; presents either the captured or the live word.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            resp_v_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] resp_instr_o
);

  logic            hold_v_q, hold_v_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;

  always_comb begin
    hold_v_d     = hold_v_q;
    hold_instr_d = hold_instr_q;
    if (flush_i || !stall_i) begin
      hold_v_d = 1'b0;
    end else if (resp_v_i && !hold_v_q) begin
      // First stalled edge with a live response: this is the last cycle rdata is valid.
      hold_v_d     = 1'b1;
      hold_instr_d = rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q     <= 1'b0;
      hold_instr_q <= '0;
    end else begin
      hold_v_q     <= hold_v_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign resp_instr_o = hold_v_q ? hold_instr_q : rdata_i;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues reads to a 1-cycle synchronous instruction memory, loads
// the IF/ID register, and runs the break/continue halt protocol on the sentinel PC.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     AW     = 8,
  parameter logic [XLEN-1:0] NOP    = IF_NOP,
  parameter logic [XLEN-1:0] BRK_PC = IF_BRK_PC
) (
  input logic       clk,
  input logic       rst_n,
  if_stage_if.slave bus
);

  if_state_e       state_q, state_d;
  logic            resp_v_q, resp_v_d;
  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  logic            brk_hit;
  logic            imem_en;
  logic            resume;
  logic [XLEN-1:0] resp_instr;

  assign brk_hit = (bus.PC == BRK_PC);
  assign imem_en = (state_q == StRun) && !brk_hit && !bus.Stall;
  assign resume  = (state_q == StHalt) && bus.Continue;

  if_skid_buf u_skid_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (bus.Stall),
    .flush_i      (bus.Flush),
    .resp_v_i     (resp_v_q),
    .rdata_i      (bus.IMemRdata),
    .resp_instr_o (resp_instr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (brk_hit)      state_d = StHalt;
      StHalt:  if (bus.Continue) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    resp_v_d = resp_v_q;
    pc_d     = pc_q;
    if (bus.Flush) begin
      resp_v_d = 1'b0;
    end else if (!bus.Stall) begin
      resp_v_d = imem_en;
      pc_d     = bus.PC;
    end
    // Leaving HALT restarts fetch cleanly from the reloaded PC.
    if (resume) begin
      resp_v_d = 1'b0;
    end
  end

  always_comb begin
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (bus.Flush) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP;
    end else if (!bus.Stall) begin
      if_id_d.valid    = resp_v_q;
      if_id_d.instr    = resp_v_q ? resp_instr : NOP;
      if_id_d.pc       = pc_q;
      if_id_d.pc_plus4 = pc_inc(pc_q);
      if (resp_v_q) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      resp_v_q      <= 1'b0;
      pc_q          <= '0;
      if_id_q       <= '{valid: 1'b0, instr: NOP, pc: '0, pc_plus4: '0};
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      resp_v_q      <= resp_v_d;
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.PCPlus4       = pc_inc(bus.PC);
  assign bus.IMemEn        = imem_en;
  assign bus.IMemAddr      = bus.PC[AW+1:2];
  assign bus.IF_ID_Instr   = if_id_q.instr;
  assign bus.IF_ID_PC      = if_id_q.pc;
  assign bus.IF_ID_PCPlus4 = if_id_q.pc_plus4;
  assign bus.IF_ID_Valid   = if_id_q.valid;
  assign bus.Halted        = (state_q == StHalt);
  assign bus.FetchCount    = fetch_count_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly downstream of the PC register. It takes the current PC, issues a read to a synchronous instruction memory (1-cycle latency) and returns PCPlus4 to the PC register. It loads the IF/ID pipeline register with instruction, PC and PC+4, and handles pipeline stall and flush. It also runs the break/continue halt protocol, signalled by the sentinel PC 32'hFFFFFFFF.

Parameters:
AW, 8, instruction-memory word-address width (memory depth 2^AW words)
NOP, 32'h00000000, instruction value inserted into IF/ID on bubble/flush
BRK_PC, 32'hFFFFFFFF, break sentinel PC value

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
PC  input  32  current PC (PCNext from the PC register)
Stall  input  1  hazard stall; hold IF/ID and in-flight fetch
Flush  input  1  branch/jump taken; discard wrong-path fetch
Continue  input  1  debugger resume pulse (same pulse the PC register sees)
IMemRdata  input  32  instruction memory read data; valid the cycle after the request
PCPlus4  output  32  PC+4, combinational, to the PC register
IMemEn  output  1  instruction memory read enable
IMemAddr  output  AW  word address = PC[AW+1:2]
IF_ID_Instr  output  32  registered instruction
IF_ID_PC  output  32  registered PC of IF_ID_Instr
IF_ID_PCPlus4  output  32  registered IF_ID_PC+4
IF_ID_Valid  output  1  IF/ID holds a real instruction
Halted  output  1  stage is in HALT state
FetchCount  output  32  count of valid instructions loaded into IF/ID

Behaviour:
- Reset (async, rst_n=0): state RUN, IF_ID_Instr=NOP, IF_ID_PC=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, Halted=0, FetchCount=0, pc_q=0, resp_v=0, hold_v=0. Reset mid-fetch discards everything; first fetch is at PC=0 on the first cycle after release.
- PCPlus4 = PC+4 modulo 2^32. 32'hFFFFFFFC+4 = 0. PC[1:0] is ignored.
- States: RUN, HALT. RUN->HALT at an edge where PC==BRK_PC. HALT->RUN at an edge where Continue=1. Continue in RUN is ignored. Halted = (state==HALT).
- IMemEn = (state==RUN) && (PC!=BRK_PC) && !Stall. IMemAddr is always driven from PC.
- Response register, updated each edge:
  - Flush: resp_v<=0.
  - Else if Stall: hold resp_v and pc_q.
  - Else: resp_v<=IMemEn, pc_q<=PC.
- Skid buffer: the memory output is not guaranteed stable while IMemEn=0.
  - At an edge with Stall && resp_v && !hold_v && !Flush: hold_instr<=IMemRdata, hold_v<=1.
  - hold_v clears on any edge with !Stall or Flush.
  - resp_instr = hold_v ? hold_instr : IMemRdata.
- IF/ID update per edge, priority Flush > Stall > normal:
  - Flush: Valid<=0, Instr<=NOP; PC fields unchanged.
  - Stall: all IF/ID fields hold.
  - Normal: Valid<=resp_v, Instr<=resp_v ? resp_instr : NOP, IF_ID_PC<=pc_q, IF_ID_PCPlus4<=pc_q+4.
- Latency: an instruction at PC p requested in cycle n (no stall/flush) appears in IF/ID in cycle n+2.
- The sentinel is never fetched. Cycles with PC==BRK_PC produce bubbles (Valid=0).
- HALT->RUN: any response pending at the Continue edge is dropped (resp_v<=0). Fetch restarts from the PC the PC register reloads.
- Simultaneous events:
  - Flush+Stall: Flush wins.
  - Continue+Flush: both act (state->RUN, resp_v<=0).
  - Stall in HALT: no effect on state.
- FetchCount increments (wrapping) on each edge that loads IF_ID_Valid<=1.

Decomposition:
- Shared pipeline package holds: NOP encoding, BRK_PC, the state encoding (RUN=1'b0, HALT=1'b1) and the IF/ID bundle field widths.
- One natural sub-module: if_skid_buf (hold_instr/hold_v register plus the output mux).
- FSM, response register and IF/ID register stay in if_stage.

Test Plan:
- Straight-line fetch: reset, memory word k = 32'h1000_0000+k, PC increments by 4 from 0 -> IF_ID_Instr=32'h10000000 with IF_ID_PC=0 two cycles after reset release, then one word per cycle; IF_ID_PCPlus4=IF_ID_PC+4; FetchCount=N after N loads.
- Stall with skid: 3-cycle Stall while the response for PC=8 is in flight, memory output corrupted to 32'hDEADBEEF during the stall -> IF/ID holds its prior value; after Stall drops, IF_ID_Instr=word 2 with PC=8, no duplicate or skipped instruction.
- Flush: Flush for 1 cycle while PC=0x10 is fetched, PC redirected to 0x40 -> next IF/ID cycle Valid=0/Instr=NOP; next valid is PC=0x40; 0x10 never appears. Flush+Stall in the same cycle -> flush result.
- Break/continue: PC=32'hFFFFFFFF -> IMemEn=0, Halted=1 next cycle, IF_ID_Valid=0 thereafter. Continue pulse with PC reloaded to 0x20 -> Halted=0, IF_ID_PC=0x20 valid two cycles later.
- Wrap: PC=32'hFFFFFFFC -> PCPlus4=0.
- Async reset mid-stall: rst_n low for half a cycle -> all outputs at reset values immediately, without waiting for a clock edge.
